// File: rtl/ks_pkg.sv
// rtl/ks_pkg.sv - shared width, result word and elastic-register state types
// The ovf field of ks_res_t exists only when KS_SUM_OVF_EN is defined.
package ks_pkg;

   localparam int KS_WIDTH = 32;

   typedef struct packed {
      logic [KS_WIDTH-1:0] sum;
      logic                cout;
      logic                zero;
`ifdef KS_SUM_OVF_EN
      logic                ovf;
`endif
   } ks_res_t;

   // Encoding is {main valid, skid valid}.
   typedef enum logic [1:0] {
      SKID_EMPTY = 2'b00,
      SKID_ONE   = 2'b10,
      SKID_FULL  = 2'b11
   } skid_state_t;

endpackage

// File: rtl/ks_skid_reg.sv
// rtl/ks_skid_reg.sv - 2-entry elastic register (main + skid), strict FIFO order
// Upstream ready comes only from the skid valid bit, never from downstream ready.
module ks_skid_reg
   import ks_pkg::*;
#(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         s_tvalid,
   output logic         s_tready,
   input  logic [W-1:0] s_tdata,
   output logic         m_tvalid,
   input  logic         m_tready,
   output logic [W-1:0] m_tdata
);

   skid_state_t  state;
   skid_state_t  state_nxt;
   logic [W-1:0] m_data;
   logic [W-1:0] s_data;
   logic         in_xfer;
   logic         out_xfer;
   logic         load_m_in;
   logic         load_m_skid;
   logic         load_s;

   assign s_tready = ~state[0] & ~rst;
   assign m_tvalid = state[1];
   assign m_tdata  = m_data;
   assign in_xfer  = s_tvalid & s_tready;
   assign out_xfer = state[1] & m_tready;

   always_comb begin
      state_nxt   = state;
      load_m_in   = 1'b0;
      load_m_skid = 1'b0;
      load_s      = 1'b0;
      case (state)
         SKID_EMPTY: begin
            if (in_xfer) begin
               load_m_in = 1'b1;
               state_nxt = SKID_ONE;
            end
         end
         SKID_ONE: begin
            if (in_xfer && out_xfer) begin
               load_m_in = 1'b1;
            end else if (in_xfer) begin
               load_s    = 1'b1;
               state_nxt = SKID_FULL;
            end else if (out_xfer) begin
               state_nxt = SKID_EMPTY;
            end
         end
         SKID_FULL: begin
            if (out_xfer) begin
               load_m_skid = 1'b1;
               state_nxt   = SKID_ONE;
            end
         end
         default: state_nxt = SKID_EMPTY;
      endcase
   end

   // Data registers keep their value when a word leaves, so outputs hold while idle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= SKID_EMPTY;
         m_data <= '0;
         s_data <= '0;
      end else begin
         state <= state_nxt;
         if (load_m_in) begin
            m_data <= s_tdata;
         end else if (load_m_skid) begin
            m_data <= s_data;
         end
         if (load_s) begin
            s_data <= s_tdata;
         end
      end
   end

endmodule

// File: rtl/ks_sum_stage.sv
// rtl/ks_sum_stage.sv - Kogge-Stone sum/flag stage feeding an elastic output register
// Define KS_SUM_OVF_EN to add the o_ovf port and carry the overflow bit through storage.
module ks_sum_stage
   import ks_pkg::*;
#(
   parameter int WIDTH = KS_WIDTH
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic             i_c0,
   input  logic [WIDTH-1:0] i_gk,
   input  logic [WIDTH-1:0] i_p_save,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [WIDTH-1:0] o_sum,
   output logic             o_cout,
`ifdef KS_SUM_OVF_EN
   output logic             o_ovf,
`endif
   output logic             o_zero
);

   localparam int RES_W = $bits(ks_res_t);

   logic [WIDTH-1:0] carry;
   logic [WIDTH-1:0] sum;
   ks_res_t          res_in;
   ks_res_t          res_out;

   // Carry into bit k is the resolved group generate of bits k-1..0.
   assign carry = {i_gk[WIDTH-2:0], i_c0};
   assign sum   = i_p_save ^ carry;

   assign res_in.sum  = sum;
   assign res_in.cout = i_gk[WIDTH-1];
   assign res_in.zero = ~|sum;
`ifdef KS_SUM_OVF_EN
   assign res_in.ovf  = i_gk[WIDTH-2] ^ i_gk[WIDTH-1];
   assign o_ovf       = res_out.ovf;
`else
`endif

   ks_skid_reg #(
      .W (RES_W)
   ) u_skid (
      .clk      (i_clk),
      .rst      (i_rst),
      .s_tvalid (i_valid),
      .s_tready (o_ready),
      .s_tdata  (res_in),
      .m_tvalid (o_valid),
      .m_tready (i_ready),
      .m_tdata  (res_out)
   );

   assign o_sum  = res_out.sum;
   assign o_cout = res_out.cout;
   assign o_zero = res_out.zero;

endmodule

// File: tb/tb_ks_sum_stage.sv
// tb/tb_ks_sum_stage.sv - directed and streaming checks for ks_sum_stage
module tb_ks_sum_stage;

   logic        clk = 1'b0;
   logic        i_rst;
   logic        i_valid;
   logic        o_ready;
   logic        i_c0;
   logic [31:0] i_gk;
   logic [31:0] i_p_save;
   logic        o_valid;
   logic        i_ready;
   logic [31:0] o_sum;
   logic        o_cout;
   logic        o_zero;
`ifdef KS_SUM_OVF_EN
   logic        o_ovf;
`endif

   always #5 clk = ~clk;

   ks_sum_stage dut (
      .i_clk    (clk),
      .i_rst    (i_rst),
      .i_valid  (i_valid),
      .o_ready  (o_ready),
      .i_c0     (i_c0),
      .i_gk     (i_gk),
      .i_p_save (i_p_save),
      .o_valid  (o_valid),
      .i_ready  (i_ready),
      .o_sum    (o_sum),
      .o_cout   (o_cout),
`ifdef KS_SUM_OVF_EN
      .o_ovf    (o_ovf),
`endif
      .o_zero   (o_zero)
   );

   typedef struct packed {
      logic [31:0] sum;
      logic        cout;
      logic        zero;
      logic        ovf;
   } exp_t;

   exp_t        q[$];
   exp_t        exp_cur;
   int          n_vec = 0;
   int          n_miss = 0;
   bit          stalled = 1'b0;
   bit          saw_not_ready = 1'b0;
   logic [31:0] held_sum;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
      n_vec++;
      if (obs !== want) begin
         n_miss++;
         $display("FAIL %s: got %h, want %h", tag, obs, want);
      end
   endtask

   // Upstream prefix tree modelled as a ripple chain; expected result from plain addition.
   task automatic set_word(input logic [31:0] a, input logic [31:0] b, input logic c0);
      logic [32:0] full;
      logic [31:0] g;
      logic        c;
      c = c0;
      for (int k = 0; k < 32; k++) begin
         c    = (a[k] & b[k]) | ((a[k] ^ b[k]) & c);
         g[k] = c;
      end
      full = {1'b0, a} + {1'b0, b} + {32'b0, c0};
      i_p_save = a ^ b;
      i_gk     = g;
      i_c0     = c0;
      exp_cur.sum  = full[31:0];
      exp_cur.cout = full[32];
      exp_cur.zero = (full[31:0] == 32'h0);
      exp_cur.ovf  = (a[31] == b[31]) && (full[31] != a[31]);
   endtask

   task automatic cycle(output bit acc, output bit dlv);
      exp_t e;
      @(negedge clk);
      acc = i_valid && o_ready;
      dlv = o_valid && i_ready;
      if (!o_ready && !i_rst) begin
         saw_not_ready = 1'b1;
         check("skid_without_main", 32'(o_valid), 32'd1);
      end
      if (stalled) check("stall_hold", o_sum, held_sum);
      stalled  = o_valid && !i_ready;
      held_sum = o_sum;
      if (dlv) begin
         check("q_level", 32'(q.size() != 0), 32'd1);
         if (q.size() != 0) begin
            e = q.pop_front();
            check("sum", o_sum, e.sum);
            check("cout", 32'(o_cout), 32'(e.cout));
            check("zero", 32'(o_zero), 32'(e.zero));
`ifdef KS_SUM_OVF_EN
            check("ovf", 32'(o_ovf), 32'(e.ovf));
`endif
         end
      end
      if (acc) q.push_back(exp_cur);
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input string tag);
      bit a, d;
      i_valid = 1'b0;
      i_ready = 1'b1;
      for (int k = 0; k < 10 && q.size() != 0; k++) cycle(a, d);
      check({tag, "_drain"}, 32'(q.size()), 32'd0);
   endtask

   task automatic directed(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic c0, input logic [31:0] es, input logic ec,
                           input logic ez, input logic eo);
      set_word(a, b, c0);
      i_valid = 1'b1;
      i_ready = 1'b1;
      @(posedge clk);
      #1;
      i_valid = 1'b0;
      @(negedge clk);
      check({tag, "_valid"}, 32'(o_valid), 32'd1);
      check({tag, "_sum"}, o_sum, es);
      check({tag, "_cout"}, 32'(o_cout), 32'(ec));
      check({tag, "_zero"}, 32'(o_zero), 32'(ez));
`ifdef KS_SUM_OVF_EN
      check({tag, "_ovf"}, 32'(o_ovf), 32'(eo));
`else
      if (eo === 1'bx) check({tag, "_ovf_arg"}, 32'(eo), 32'd0);
`endif
      @(posedge clk);
      #1;
      @(negedge clk);
      check({tag, "_drained"}, 32'(o_valid), 32'd0);
      check({tag, "_hold"}, o_sum, es);
      @(posedge clk);
      #1;
   endtask

   initial begin
      bit acc, dlv;
      int idx, n_in, n_out;

      i_rst    = 1'b1;
      i_valid  = 1'b0;
      i_ready  = 1'b0;
      i_c0     = 1'b0;
      i_gk     = '0;
      i_p_save = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_valid", 32'(o_valid), 32'd0);
      check("rst_sum", o_sum, 32'd0);
      check("rst_cout", 32'(o_cout), 32'd0);
      check("rst_zero", 32'(o_zero), 32'd0);
      check("rst_ready", 32'(o_ready), 32'd0);
`ifdef KS_SUM_OVF_EN
      check("rst_ovf", 32'(o_ovf), 32'd0);
`endif
      @(posedge clk);
      #1;
      i_rst = 1'b0;
      @(negedge clk);
      check("rel_ready", 32'(o_ready), 32'd1);
      check("rel_valid", 32'(o_valid), 32'd0);
      @(posedge clk);
      #1;

      directed("v_ffff", 32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b0);
      directed("v_7fff", 32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b0, 1'b1);
      directed("v_1234", 32'h12345678, 32'h11111111, 1'b1, 32'h2345678A, 1'b0, 1'b0, 1'b0);
      directed("v_8000", 32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b1);
      directed("v_cin",  32'h00000000, 32'h00000000, 1'b1, 32'h00000001, 1'b0, 1'b0, 1'b0);

      // Words 1..8 with downstream stalled in cycles 2..6.
      stalled       = 1'b0;
      saw_not_ready = 1'b0;
      idx           = 0;
      for (int cyc = 1; cyc <= 40 && idx < 8; cyc++) begin
         set_word(32'(idx + 1), 32'h0, 1'b0);
         i_valid = 1'b1;
         i_ready = !(cyc >= 2 && cyc <= 6);
         cycle(acc, dlv);
         if (acc) idx++;
      end
      check("bp_all_sent", 32'(idx), 32'd8);
      check("bp_ready_drop", 32'(saw_not_ready), 32'd1);
      drain("bp");

      // Fill both entries, then reset with a word presented in the same cycle.
      stalled = 1'b0;
      i_ready = 1'b0;
      for (int k = 0; k < 2; k++) begin
         set_word(32'hA000 + 32'(k), 32'h5, 1'b0);
         i_valid = 1'b1;
         cycle(acc, dlv);
      end
      @(negedge clk);
      check("full_ready", 32'(o_ready), 32'd0);
      check("full_valid", 32'(o_valid), 32'd1);
      i_rst = 1'b1;
      set_word(32'hDEAD, 32'hBEEF, 1'b1);
      i_valid = 1'b1;
      #1;
      check("rst_mid_ready", 32'(o_ready), 32'd0);
      @(posedge clk);
      #1;
      i_rst   = 1'b0;
      i_valid = 1'b0;
      i_ready = 1'b1;
      @(negedge clk);
      check("rst_mid_valid", 32'(o_valid), 32'd0);
      check("rst_mid_sum", o_sum, 32'd0);
      check("rst_mid_cout", 32'(o_cout), 32'd0);
      check("rst_mid_ready_rel", 32'(o_ready), 32'd1);
      @(posedge clk);
      #1;
      q.delete();
      stalled = 1'b0;
      for (int k = 0; k < 4; k++) cycle(acc, dlv);

      // Downstream ready toggling every cycle, upstream always valid.
      stalled = 1'b0;
      n_in    = 0;
      n_out   = 0;
      for (int cyc = 0; cyc < 40; cyc++) begin
         set_word($urandom, $urandom, 1'b0);
         i_valid = 1'b1;
         i_ready = cyc[0];
         cycle(acc, dlv);
         n_in  += int'(acc);
         n_out += int'(dlv);
      end
      check("tog_in", 32'(n_in), 32'd21);
      check("tog_out", 32'(n_out), 32'd20);
      drain("tog");

      // Random operand sweep with random valid/ready.
      stalled = 1'b0;
      n_in    = 0;
      for (int cyc = 0; cyc < 40000 && n_in < 10000; cyc++) begin
         set_word($urandom, $urandom, 1'($urandom_range(0, 1)));
         i_valid = ($urandom_range(0, 7) != 0);
         i_ready = ($urandom_range(0, 3) != 0);
         cycle(acc, dlv);
         n_in += int'(acc);
      end
      check("rand_words_in", 32'(n_in), 32'd10000);
      drain("rand");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
